// File: rtl/alu_cmd_issuer.sv
// Command front end for a combinational ALU: a FIFO of tagged commands, a registered
// ALU drive, and tagged responses returned in order over a valid/ready handshake.
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shamt,
  input  logic [3:0]       cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  input  logic             alu_zeroFlag,
  input  logic             alu_overFlowFlag,
  input  logic             alu_signFlag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
    logic [3:0]       tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [3:0]    tag_q;
  logic          push;
  logic          pop;
  logic          not_empty;

  always_comb begin
    not_empty = (count != '0);
    cmd_ready = (count != CW'(DEPTH));
    push      = cmd_valid && cmd_ready;
    // A pop always feeds DRIVE: either from IDLE or on the same edge a response is taken.
    pop       = not_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
    busy      = not_empty || (state != IDLE);
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b, sh: cmd_shamt, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= IDLE;
      tag_q          <= '0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_flags      <= '0;
      rsp_tag        <= '0;
      rsp_err        <= 1'b0;
      err_count      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      if (pop) begin
        alu_opcode     <= head.op;
        alu_input1     <= head.a;
        alu_input2     <= head.b;
        alu_shiftValue <= head.sh;
        tag_q          <= head.tag;
      end

      case (state)
        IDLE: begin
          if (pop) state <= DRIVE;
        end
        DRIVE: begin
          if (alu_opcode > 4'd8) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_signFlag, alu_overFlowFlag, alu_zeroFlag, alu_carryFlag};
            rsp_err    <= (alu_opcode == 4'd6) && (alu_input2 == '0);
          end
          rsp_tag   <= tag_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            rsp_valid <= 1'b0;
            state     <= pop ? DRIVE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural ALU attached to its drive port.
module tb_alu_cmd_issuer;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flags;
    logic [3:0] tag;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic [4:0] cmd_shamt;
  logic [3:0] cmd_tag;
  logic [3:0] alu_opcode;
  logic [7:0] alu_input1, alu_input2;
  logic [4:0] alu_shiftValue;
  logic [7:0] alu_result;
  logic       alu_carryFlag, alu_zeroFlag, alu_overFlowFlag, alu_signFlag;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags, rsp_tag;
  logic       rsp_err, busy;
  logic [7:0] err_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_rsp = 0;
  bit   last_valid = 0;
  bit   spacing_on = 0;
  bit   watch_ready = 0;
  bit   ready_low = 0;
  exp_t q[$];

  alu_cmd_issuer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
    .alu_overFlowFlag(alu_overFlowFlag), .alu_signFlag(alu_signFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {sign, overflow, zero, carry, result}; undefined opcodes give junk so dropping it is visible.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] sh);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    int unsigned s;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    s = int'(sh) % 8;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << sh;
      4'd5: r = (a << s) | (a >> (8 - s));
      4'd6: r = (b == 8'd0) ? 8'hFF : a / b;
      4'd7: r = b;
      4'd8: r = (a == b) ? 8'd1 : 8'd0;
      default: begin r = 8'hAA; c = 1'b1; end
    endcase
    return {r[7], v, (r == 8'd0), c, r};
  endfunction

  always_comb begin
    {alu_signFlag, alu_overFlowFlag, alu_zeroFlag, alu_carryFlag, alu_result} =
      alu_f(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
  end

  function automatic exp_t mk(input logic [7:0] r, input logic [3:0] f, input logic [3:0] t, input logic e);
    return '{res: r, flags: f, tag: t, err: e};
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [4:0] sh, input logic [3:0] t);
    logic [11:0] o;
    if (op > 4'd8) return mk(8'd0, 4'd0, t, 1'b1);
    o = alu_f(op, a, b, sh);
    return mk(o[7:0], o[11:8], t, (op == 4'd6) && (b == 8'd0));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (watch_ready && !cmd_ready) ready_low = 1;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got tag %0h want no response (t=%0t)", rsp_tag, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_flags", rsp_flags, e.flags);
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_err", rsp_err, e.err);
        n_rsp++;
      end
      if (spacing_on && last_valid) chk("rsp_spacing", cyc - last_cyc, 2);
      last_cyc   = cyc;
      last_valid = 1;
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] sh, input logic [3:0] t, input exp_t e);
    bit acc;
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_tag = t;
    forever begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 32'(acc), 1);
        break;
      end
    end
    if (acc) q.push_back(e);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap_r;
    logic [3:0] snap_f, snap_t;
    logic       snap_e;
    bit         stable, any;
    int         base;

    rst = 1'b1; cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_shamt = 0; cmd_tag = 0;
    rsp_ready = 1'b0;
    do_reset();

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_drive", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, 0);
    chk("rst_rsp_fields", {rsp_result, rsp_flags, rsp_tag, rsp_err}, 0);
    chk("rst_err_count", err_count, 0);

    // Single ADD: latency 2 from acceptance
    send(4'd0, 8'h05, 8'h03, 5'd0, 4'd3, mk(8'h08, 4'b0000, 4'd3, 1'b0));
    @(posedge clk); #1;
    chk("add_valid_e1", rsp_valid, 0);
    chk("add_busy_e1", busy, 1);
    chk("add_alu_drive", {alu_opcode, alu_input1, alu_input2}, {4'd0, 8'h05, 8'h03});
    @(posedge clk); #1;
    chk("add_valid_e2", rsp_valid, 1);
    rsp_ready = 1'b1;
    wait_drain();

    // Back-to-back stream, responses every 2 cycles
    last_valid = 0; spacing_on = 1; ready_low = 0; watch_ready = 1;
    send(4'd0, 8'h7F, 8'h01, 5'd0, 4'd0, mk(8'h80, 4'b1100, 4'd0, 1'b0));
    send(4'd1, 8'h05, 8'h05, 5'd0, 4'd1, mk(8'h00, 4'b0010, 4'd1, 1'b0));
    send(4'd2, 8'hF0, 8'h3C, 5'd0, 4'd2, mk(8'h30, 4'b0000, 4'd2, 1'b0));
    send(4'd3, 8'h81, 8'h02, 5'd0, 4'd3, mk(8'h83, 4'b1000, 4'd3, 1'b0));
    send(4'd4, 8'h81, 8'h00, 5'd1, 4'd4, mk(8'h02, 4'b0000, 4'd4, 1'b0));
    send(4'd5, 8'h81, 8'h00, 5'd1, 4'd5, mk(8'h03, 4'b0000, 4'd5, 1'b0));
    wait_drain();
    watch_ready = 0; spacing_on = 0;
    chk("stream_cmd_ready_low", ready_low, 0);

    // Back-pressure: DEPTH+1 held, sixth stalls, outputs frozen
    rsp_ready = 1'b0;
    send(4'd6, 8'h64, 8'h07, 5'd0, 4'd8,  mk(8'h0E, 4'b0000, 4'd8, 1'b0));
    send(4'd7, 8'h00, 8'h9A, 5'd0, 4'd9,  mk(8'h9A, 4'b1000, 4'd9, 1'b0));
    send(4'd8, 8'h33, 8'h33, 5'd0, 4'd10, mk(8'h01, 4'b0000, 4'd10, 1'b0));
    send(4'd8, 8'h33, 8'h34, 5'd0, 4'd11, mk(8'h00, 4'b0010, 4'd11, 1'b0));
    send(4'd0, 8'hFF, 8'h01, 5'd0, 4'd12, mk(8'h00, 4'b0011, 4'd12, 1'b0));
    chk("bp_full", cmd_ready, 0);
    chk("bp_valid", rsp_valid, 1);
    snap_r = rsp_result; snap_f = rsp_flags; snap_t = rsp_tag; snap_e = rsp_err;
    cmd_valid = 1'b1; cmd_opcode = 4'd5; cmd_a = 8'h80; cmd_b = 8'h00; cmd_shamt = 5'd9; cmd_tag = 4'd13;
    stable = 1; any = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_result !== snap_r || rsp_flags !== snap_f || rsp_tag !== snap_t || rsp_err !== snap_e)
        stable = 0;
      if (cmd_ready) any = 1;
    end
    chk("bp_rsp_stable", stable, 1);
    chk("bp_stall", any, 0);
    chk("bp_head_tag", rsp_tag, 4'd8);
    rsp_ready = 1'b1;
    base = n_rsp;
    send(4'd5, 8'h80, 8'h00, 5'd9, 4'd13, mk(8'h01, 4'b0000, 4'd13, 1'b0));
    wait_drain();
    chk("bp_count", n_rsp - base, 6);

    // Errors and err_count saturation
    do_reset();
    rsp_ready = 1'b1;
    send(4'hC, 8'h01, 8'h02, 5'd0, 4'd1, mk(8'h00, 4'b0000, 4'd1, 1'b1));
    send(4'd6, 8'h10, 8'h00, 5'd0, 4'd2, mk(8'hFF, 4'b1000, 4'd2, 1'b1));
    wait_drain();
    chk("err_count_2", err_count, 2);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] t;
      t = 4'(i);
      send(4'hF, 8'(i), 8'h5A, 5'd3, t, mk(8'h00, 4'b0000, t, 1'b1));
    end
    wait_drain();
    chk("err_count_sat", err_count, 8'hFF);

    // FIFO wrap with random back-pressure
    do_reset();
    base = n_rsp;
    begin
      bit done;
      done = 0;
      fork
        begin
          for (int i = 0; i < 12; i++) begin
            logic [3:0] op, t;
            logic [7:0] a, b;
            logic [4:0] sh;
            op = 4'($urandom_range(0, 10)); a = 8'($urandom); b = 8'($urandom);
            sh = 5'($urandom); t = 4'(i);
            send(op, a, b, sh, t, model(op, a, b, sh, t));
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            rsp_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    rsp_ready = 1'b1;
    wait_drain();
    chk("wrap_count", n_rsp - base, 12);

    // Reset while holding a response with three commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] t;
      t = 4'(i);
      send(4'd7, 8'h00, 8'(i), 5'd0, t, mk(8'(i), 4'b0000, t, 1'b0));
    end
    chk("midrst_in_resp", rsp_valid, 1);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    any = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) any = 1;
    end
    chk("midrst_no_stale", any, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
